// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounces three load buttons, latches operands/opcode from the switches
// into held ALU input registers and captures the ALU result once all operands are present.
module alu_operand_loader #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int NB_SW   = 8,
    parameter int DB_CNT  = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    input  logic [NB_DATA-1:0] i_result,
    output logic [NB_DATA-1:0] o_dato_a,
    output logic [NB_DATA-1:0] o_dato_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_result_valid,
    output logic               o_op_err
);
    localparam int CW = $clog2(DB_CNT);
    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);

    typedef enum logic [1:0] {IDLE, COLLECT, CAPTURE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [2:0]           btn, sync1_q, sync2_q, stable_q, stable_d, stable_prev_q, pulse, wrap;
    logic [2:0][CW-1:0]   cnt_q, cnt_d;
    logic [NB_DATA-1:0]   dato_a_q, dato_a_d, dato_b_q, dato_b_d, result_q, result_d;
    logic [NB_OP-1:0]     op_q, op_d, op_sw;
    logic                 flag_a_q, flag_a_d, flag_b_q, flag_b_d, flag_op_q, flag_op_d;
    logic                 valid_q, valid_d, err_q, err_d, op_legal, load_op, load;

    assign btn = {i_btn_op, i_btn_b, i_btn_a};

    // Counter restarts whenever the synced input agrees with the stable state.
    always_comb begin
        cnt_d = '0;
        wrap  = '0;
        for (int i = 0; i < 3; i++) begin
            wrap[i]  = (sync2_q[i] ^ stable_q[i]) && (cnt_q[i] == CW'(DB_CNT - 1));
            cnt_d[i] = (sync2_q[i] == stable_q[i] || wrap[i]) ? '0 : cnt_q[i] + CW'(1);
        end
        stable_d = stable_q ^ wrap;
    end

    assign pulse    = stable_q & ~stable_prev_q;
    assign op_sw    = i_sw[NB_OP-1:0];
    assign op_legal = op_sw inside {NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
                                    NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b000011),
                                    NB_OP'(6'b000010), NB_OP'(6'b100111)};
    assign load_op  = pulse[2] & op_legal;
    assign load     = pulse[0] | pulse[1] | load_op;

    always_comb begin
        dato_a_d  = pulse[0] ? i_sw[NB_DATA-1:0] : dato_a_q;
        dato_b_d  = pulse[1] ? i_sw[NB_DATA-1:0] : dato_b_q;
        op_d      = load_op ? op_sw : op_q;
        err_d     = pulse[2] ? ~op_legal : err_q;
        flag_a_d  = flag_a_q | pulse[0];
        flag_b_d  = flag_b_q | pulse[1];
        flag_op_d = flag_op_q | load_op;
        state_d   = state_q;
        case (state_q)
            IDLE:    state_d = load ? COLLECT : IDLE;
            COLLECT: state_d = (load && flag_a_d && flag_b_d && flag_op_d) ? CAPTURE : COLLECT;
            CAPTURE: state_d = load ? CAPTURE : HOLD;
            HOLD:    state_d = load ? CAPTURE : HOLD;
        endcase
        result_d = (state_q == CAPTURE && !load) ? i_result : result_q;
        valid_d  = (state_q == CAPTURE && !load) ? 1'b1 : (state_q == HOLD && load) ? 1'b0 : valid_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
            dato_a_q      <= '0;
            dato_b_q      <= '0;
            op_q          <= OP_ADD;
            result_q      <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            flag_a_q      <= 1'b0;
            flag_b_q      <= 1'b0;
            flag_op_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= btn;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            dato_a_q      <= dato_a_d;
            dato_b_q      <= dato_b_d;
            op_q          <= op_d;
            result_q      <= result_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            flag_a_q      <= flag_a_d;
            flag_b_q      <= flag_b_d;
            flag_op_q     <= flag_op_d;
        end
    end

    assign o_dato_a       = dato_a_q;
    assign o_dato_b       = dato_b_q;
    assign o_operation    = op_q;
    assign o_result       = result_q;
    assign o_result_valid = valid_q;
    assign o_op_err       = err_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed vector table plus hand sequences for timing, bounce and reset.
module tb_alu_operand_loader;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] sw = '0;
    logic       ba = 1'b0, bb = 1'b0, bo = 1'b0;
    logic [7:0] res_in, a, b, res;
    logic [5:0] op;
    logic       valid, err;
    int         n_cmp = 0, n_err = 0, falls = 0;
    logic       pv = 1'b0;

    alu_operand_loader #(.NB_DATA(8), .NB_OP(6), .NB_SW(8), .DB_CNT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw), .i_btn_a(ba), .i_btn_b(bb), .i_btn_op(bo),
        .i_result(res_in), .o_dato_a(a), .o_dato_b(b), .o_operation(op), .o_result(res),
        .o_result_valid(valid), .o_op_err(err));

    // Tiny ALU stand-in: SUB when the opcode says so, ADD otherwise.
    assign res_in = (op == 6'b100010) ? a - b : a + b;

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] m;
        logic [7:0] sw;
        logic [7:0] a, b;
        logic [5:0] op;
        logic       err, v;
        logic [7:0] r;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] m, input logic [7:0] v);
        sw = v;
        {bo, bb, ba} = m;
        edges(10);
        {bo, bb, ba} = 3'b000;
        edges(12);
    endtask

    task automatic step_b(input logic lvl, input int n);
        bb = lvl;
        repeat (n) begin
            edges(1);
            if (pv && !valid) falls++;
            pv = valid;
        end
    endtask

    initial begin
        tbl[0] = '{3'b001, 8'h05, 8'h05, 8'h00, 6'h20, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{3'b010, 8'h03, 8'h05, 8'h03, 6'h20, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{3'b100, 8'h20, 8'h05, 8'h03, 6'h20, 1'b0, 1'b1, 8'h08};
        tbl[3] = '{3'b100, 8'h3F, 8'h05, 8'h03, 6'h20, 1'b1, 1'b1, 8'h08};
        tbl[4] = '{3'b100, 8'h22, 8'h05, 8'h03, 6'h22, 1'b0, 1'b1, 8'h02};
        tbl[5] = '{3'b001, 8'h10, 8'h10, 8'h03, 6'h22, 1'b0, 1'b1, 8'h0D};
        tbl[6] = '{3'b100, 8'hE0, 8'h10, 8'h03, 6'h20, 1'b0, 1'b1, 8'h13};

        edges(3);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            edges(1);
            chk("idle_outputs", {a, b, op, err, valid, res}, {8'h00, 8'h00, 6'h20, 1'b0, 1'b0, 8'h00});
        end

        for (int i = 0; i < 7; i++) begin
            press(tbl[i].m, tbl[i].sw);
            chk($sformatf("v%0d_a", i), a, tbl[i].a);
            chk($sformatf("v%0d_b", i), b, tbl[i].b);
            chk($sformatf("v%0d_op", i), op, tbl[i].op);
            chk($sformatf("v%0d_err", i), err, tbl[i].err);
            chk($sformatf("v%0d_valid", i), valid, tbl[i].v);
            chk($sformatf("v%0d_result", i), res, tbl[i].r);
        end

        // Load latency: press first sampled at edge 1 loads at edge 7.
        sw = 8'h5A;
        ba = 1'b1;
        edges(6);
        chk("lat_a_before", a, 8'h10);
        chk("lat_valid_before", valid, 1'b1);
        edges(1);
        chk("lat_a_loaded", a, 8'h5A);
        chk("lat_valid_low", valid, 1'b0);
        edges(1);
        chk("lat_valid_back", valid, 1'b1);
        chk("lat_result", res, 8'h5D);
        ba = 1'b0;
        edges(12);

        // Simultaneous A and B while in HOLD.
        sw = 8'h07;
        {bb, ba} = 2'b11;
        edges(6);
        chk("sim_valid_before", valid, 1'b1);
        edges(1);
        chk("sim_a", a, 8'h07);
        chk("sim_b", b, 8'h07);
        chk("sim_valid_low", valid, 1'b0);
        edges(1);
        chk("sim_valid_back", valid, 1'b1);
        chk("sim_result", res, 8'h0E);
        {bb, ba} = 2'b00;
        edges(12);

        // Bounce then steady: exactly one load.
        sw = 8'h09;
        pv = valid;
        falls = 0;
        step_b(1'b1, 2); step_b(1'b0, 1); step_b(1'b1, 3); step_b(1'b0, 1);
        step_b(1'b1, 1); step_b(1'b0, 1); step_b(1'b1, 10); step_b(1'b0, 15);
        chk("bounce_loads", falls, 1);
        chk("bounce_b", b, 8'h09);
        chk("bounce_result", res, 8'h10);

        // A lone 3-cycle glitch never loads.
        sw = 8'h0F;
        falls = 0;
        step_b(1'b1, 3); step_b(1'b0, 15);
        chk("glitch_loads", falls, 0);
        chk("glitch_b", b, 8'h09);

        // Asynchronous reset mid-debounce.
        sw = 8'h77;
        ba = 1'b1;
        edges(4);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_db_outputs", {a, b, op, err, valid, res}, {8'h00, 8'h00, 6'h20, 1'b0, 1'b0, 8'h00});
        ba = 1'b0;
        edges(2);
        rst_n = 1'b1;
        edges(20);
        chk("rst_db_no_load", a, 8'h00);

        // Asynchronous reset while in CAPTURE.
        press(3'b001, 8'h01);
        press(3'b010, 8'h02);
        sw = 8'h20;
        bo = 1'b1;
        edges(7);
        chk("cap_a", a, 8'h01);
        chk("cap_b", b, 8'h02);
        chk("cap_valid", valid, 1'b0);
        #2 rst_n = 1'b0;
        bo = 1'b0;
        #1;
        chk("rst_cap_outputs", {a, b, op, err, valid, res}, {8'h00, 8'h00, 6'h20, 1'b0, 1'b0, 8'h00});
        edges(2);
        rst_n = 1'b1;
        edges(20);
        chk("rst_cap_after", {a, b, op, err, valid, res}, {8'h00, 8'h00, 6'h20, 1'b0, 1'b0, 8'h00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
